regfile_wb_arbiter: RTL and testbench

- Arbitrates the single register-file write port between two writers.
  - In-order pipeline writeback (WB stage) has priority.
  - Multi-cycle multiply/divide unit (MDU) results are held in a 1-entry buffer until the port is free.
- Keeps a per-register busy scoreboard for outstanding MDU destinations, so issue can detect RAW/WAW hazards.
- Sits between WB/MDU and the register file write port.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/reg_scoreboard.sv | 47 ++++
 rtl/regfile_wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register-file writeback arbiter.
package regfile_pkg;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned SEL_W    = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             we;
    logic [SEL_W-1:0] addr;
    logic [WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bitmap for outstanding MDU destinations.
// Register 0 never becomes busy.
module reg_scoreboard #(
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int unsigned SEL_W    = regfile_pkg::SEL_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [SEL_W-1:0]    set_addr,
  input  logic                clr_en,
  input  logic [SEL_W-1:0]    clr_addr,
  input  logic [SEL_W-1:0]    chk_addr1,
  input  logic [SEL_W-1:0]    chk_addr2,
  output logic                chk_busy1,
  output logic                chk_busy2,
  output logic [NUM_REGS-1:0] busy
);
  import regfile_pkg::*;

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Next bitmap: clear on drain, set on accepted issue.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (set_en && (set_addr != '0)) begin
      busy_d[set_addr] = 1'b1;
    end
  end

  // Bitmap register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign chk_busy1 = busy_q[chk_addr1];
  assign chk_busy2 = busy_q[chk_addr2];
  assign busy      = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: WB has priority, MDU results wait in a
// 1-entry buffer; after STARVE_MAX deferred cycles WB is stalled for one
// cycle so the buffer drains. Optional forwarding from the buffer is
// enabled by defining REGFILE_WB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int unsigned WIDTH      = regfile_pkg::WIDTH,
  parameter int unsigned SEL_W      = regfile_pkg::SEL_W,
  parameter int unsigned NUM_REGS   = regfile_pkg::NUM_REGS,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_we,
  input  logic [SEL_W-1:0] pipe_waddr,
  input  logic [WIDTH-1:0] pipe_wdata,
  output logic             pipe_stall,
  input  logic             mdu_valid,
  input  logic [SEL_W-1:0] mdu_waddr,
  input  logic [WIDTH-1:0] mdu_wdata,
  output logic             mdu_ready,
  input  logic             iss_valid,
  input  logic [SEL_W-1:0] iss_dest,
  output logic             iss_ready,
  input  logic [SEL_W-1:0] chk_addr1,
  input  logic [SEL_W-1:0] chk_addr2,
  output logic             chk_busy1,
  output logic             chk_busy2,
  output logic             rf_write,
  output logic [SEL_W-1:0] rf_write_reg,
  output logic [WIDTH-1:0] rf_write_data
`ifdef REGFILE_WB_FWD_EN
  ,
  output logic             fwd_hit1,
  output logic             fwd_hit2,
  output logic [WIDTH-1:0] fwd_data1,
  output logic [WIDTH-1:0] fwd_data2
`endif
);
  import regfile_pkg::*;

  arb_state_e          state_q, state_d;
  logic [3:0]          starve_q, starve_d;
  logic                buf_valid_q, buf_valid_d;
  logic [SEL_W-1:0]    buf_addr_q, buf_addr_d;
  logic [WIDTH-1:0]    buf_data_q, buf_data_d;
  wb_req_t             grant;
  logic                drain;
  logic                mdu_accept;
  logic                sb_busy1, sb_busy2;
  logic [NUM_REGS-1:0] busy;

  // Port arbitration and starvation FSM.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    drain    = 1'b0;
    grant    = '0;
    unique case (state_q)
      NORMAL: begin
        if (pipe_we) begin
          grant.we   = 1'b1;
          grant.addr = pipe_waddr;
          grant.data = pipe_wdata;
          if (buf_valid_q) begin
            if (starve_q == 4'(STARVE_MAX - 1)) begin
              state_d = FORCE;
            end else begin
              starve_d = starve_q + 4'd1;
            end
          end
        end else if (buf_valid_q) begin
          drain      = 1'b1;
          starve_d   = '0;
          grant.we   = 1'b1;
          grant.addr = buf_addr_q;
          grant.data = buf_data_q;
        end
      end
      FORCE: begin
        drain      = 1'b1;
        starve_d   = '0;
        grant.we   = 1'b1;
        grant.addr = buf_addr_q;
        grant.data = buf_data_q;
        state_d    = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  assign mdu_ready  = !buf_valid_q || drain;
  assign mdu_accept = mdu_valid && mdu_ready;

  // Buffer next state: a drain and a refill may happen in the same cycle.
  always_comb begin
    buf_valid_d = (buf_valid_q && !drain) || mdu_accept;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    if (mdu_accept) begin
      buf_addr_d = mdu_waddr;
      buf_data_d = mdu_wdata;
    end
  end

  // State, starve counter and buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= NORMAL;
      starve_q    <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end

  assign pipe_stall    = (state_q == FORCE);
  assign rf_write      = grant.we && (grant.addr != '0);
  assign rf_write_reg  = grant.addr;
  assign rf_write_data = grant.data;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (iss_valid && iss_ready),
    .set_addr  (iss_dest),
    .clr_en    (drain),
    .clr_addr  (buf_addr_q),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_busy1 (sb_busy1),
    .chk_busy2 (sb_busy2),
    .busy      (busy)
  );

  assign iss_ready = !busy[iss_dest];

`ifdef REGFILE_WB_FWD_EN
  assign fwd_hit1  = buf_valid_q && (buf_addr_q == chk_addr1) && (chk_addr1 != '0);
  assign fwd_hit2  = buf_valid_q && (buf_addr_q == chk_addr2) && (chk_addr2 != '0);
  assign fwd_data1 = buf_data_q;
  assign fwd_data2 = buf_data_q;
  assign chk_busy1 = sb_busy1 && !fwd_hit1;
  assign chk_busy2 = sb_busy2 && !fwd_hit2;
`else
  assign chk_busy1 = sb_busy1;
  assign chk_busy2 = sb_busy2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (STARVE_MAX=4).
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        pipe_stall;
  logic        mdu_valid;
  logic [4:0]  mdu_waddr;
  logic [31:0] mdu_wdata;
  logic        mdu_ready;
  logic        iss_valid;
  logic [4:0]  iss_dest;
  logic        iss_ready;
  logic [4:0]  chk_addr1, chk_addr2;
  logic        chk_busy1, chk_busy2;
  logic        rf_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
`ifdef REGFILE_WB_FWD_EN
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        exp_write;
  } vec_t;
  vec_t vecs[6];

  regfile_wb_arbiter #(
    .WIDTH      (32),
    .SEL_W      (5),
    .NUM_REGS   (32),
    .STARVE_MAX (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_we       (pipe_we),
    .pipe_waddr    (pipe_waddr),
    .pipe_wdata    (pipe_wdata),
    .pipe_stall    (pipe_stall),
    .mdu_valid     (mdu_valid),
    .mdu_waddr     (mdu_waddr),
    .mdu_wdata     (mdu_wdata),
    .mdu_ready     (mdu_ready),
    .iss_valid     (iss_valid),
    .iss_dest      (iss_dest),
    .iss_ready     (iss_ready),
    .chk_addr1     (chk_addr1),
    .chk_addr2     (chk_addr2),
    .chk_busy1     (chk_busy1),
    .chk_busy2     (chk_busy2),
    .rf_write      (rf_write),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data)
`ifdef REGFILE_WB_FWD_EN
    ,
    .fwd_hit1      (fwd_hit1),
    .fwd_hit2      (fwd_hit2),
    .fwd_data1     (fwd_data1),
    .fwd_data2     (fwd_data2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_we    = 1'b0;
    pipe_waddr = '0;
    pipe_wdata = '0;
    mdu_valid  = 1'b0;
    mdu_waddr  = '0;
    mdu_wdata  = '0;
    iss_valid  = 1'b0;
    iss_dest   = '0;
    chk_addr1  = '0;
    chk_addr2  = '0;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Every register-file write is matched in order against the expected queue.
  always @(negedge clk) begin
    if (rf_write === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rf_unexpected: got write r%0d=0x%0h, expected no write", rf_write_reg, rf_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_write_reg !== mon_e.addr || rf_write_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL rf_order: got r%0d=0x%0h, expected r%0d=0x%0h",
                   rf_write_reg, rf_write_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd1,  32'h1111_1111, 1'b1};
    vecs[1] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1};
    vecs[2] = '{1'b1, 5'd0,  32'h0000_DEAD, 1'b0};
    vecs[3] = '{1'b0, 5'd4,  32'h0000_0444, 1'b0};
    vecs[4] = '{1'b1, 5'd16, 32'h0000_0000, 1'b1};
    vecs[5] = '{1'b1, 5'd8,  32'hA5A5_5A5A, 1'b1};

    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("reset_rf_write", rf_write, 0);
    chk("reset_stall", pipe_stall, 0);
    chk("reset_mdu_ready", mdu_ready, 1);
    chk("reset_iss_ready", iss_ready, 1);
    chk("reset_chk_busy1", chk_busy1, 0);
    chk("reset_chk_busy2", chk_busy2, 0);
    step();

    // WB pass-through vectors, including register 0 and no-write.
    for (int i = 0; i < 6; i++) begin
      pipe_we    = vecs[i].we;
      pipe_waddr = vecs[i].addr;
      pipe_wdata = vecs[i].data;
      #2;
      chk("vec_rf_write", rf_write, vecs[i].exp_write);
      chk("vec_stall", pipe_stall, 0);
      if (vecs[i].exp_write) begin
        chk("vec_rf_reg", rf_write_reg, vecs[i].addr);
        chk("vec_rf_data", rf_write_data, vecs[i].data);
        push(vecs[i].addr, vecs[i].data);
      end
      step();
    end
    idle();

    // Idle port: MDU r7 written one cycle after accept, busy[7] cleared after.
    iss_valid = 1'b1;
    iss_dest  = 5'd7;
    #2;
    chk("idle_iss_ready", iss_ready, 1);
    step();
    iss_valid = 1'b0;
    chk_addr1 = 5'd7;
    mdu_valid = 1'b1;
    mdu_waddr = 5'd7;
    mdu_wdata = 32'h1234;
    #2;
    chk("idle_busy7_set", chk_busy1, 1);
    chk("idle_accept_ready", mdu_ready, 1);
    chk("idle_no_write_yet", rf_write, 0);
    push(5'd7, 32'h1234);
    step();
    mdu_valid = 1'b0;
    #2;
    chk("idle_rf_write", rf_write, 1);
    chk("idle_rf_reg", rf_write_reg, 7);
    chk("idle_rf_data", rf_write_data, 32'h1234);
    chk("idle_drain_ready", mdu_ready, 1);
    step();
    #1;
    chk("idle_busy7_clr", chk_busy1, 0);
    chk("idle_after_write", rf_write, 0);
    idle();

    // Conflict: continuous WB, MDU r9 deferred 4 cycles then forced.
    for (int k = 0; k < 7; k++) begin
      pipe_we    = 1'b1;
      pipe_waddr = (k == 6) ? 5'd15 : 5'(10 + k);
      pipe_wdata = (k == 6) ? 32'h105 : 32'(32'h100 + k);
      mdu_valid  = (k == 0);
      mdu_waddr  = 5'd9;
      mdu_wdata  = 32'hAA;
      #2;
      if (k == 5) begin
        chk("force_stall", pipe_stall, 1);
        chk("force_rf_write", rf_write, 1);
        chk("force_rf_reg", rf_write_reg, 9);
        chk("force_rf_data", rf_write_data, 32'hAA);
        chk("force_mdu_ready", mdu_ready, 1);
        push(5'd9, 32'hAA);
      end else begin
        chk("conflict_stall", pipe_stall, 0);
        chk("conflict_rf_reg", rf_write_reg, pipe_waddr);
        push(pipe_waddr, pipe_wdata);
      end
      if (k >= 1 && k <= 4) chk("conflict_mdu_ready", mdu_ready, 0);
      step();
    end
    idle();

    // Scoreboard: second issue to 12 blocked until the drain.
    iss_valid = 1'b1;
    iss_dest  = 5'd12;
    #2;
    chk("sb_first_issue", iss_ready, 1);
    step();
    chk_addr1 = 5'd12;
    chk_addr2 = 5'd13;
    #2;
    chk("sb_waw_blocked", iss_ready, 0);
    chk("sb_busy12", chk_busy1, 1);
    chk("sb_busy13", chk_busy2, 0);
    step();
    iss_valid = 1'b0;
    mdu_valid = 1'b1;
    mdu_waddr = 5'd12;
    mdu_wdata = 32'hC0DE_0012;
    #2;
    chk("sb_busy12_held", chk_busy1, 1);
    push(5'd12, 32'hC0DE_0012);
    step();
    mdu_valid = 1'b0;
    #2;
    chk("sb_drain_reg", rf_write_reg, 12);
    chk("sb_busy12_during_drain", chk_busy1, 1);
    step();
    #1;
    chk("sb_busy12_clr", chk_busy1, 0);
    chk("sb_issue_reopen", iss_ready, 1);
    iss_valid = 1'b1;
    iss_dest  = 5'd0;
    #1;
    chk("sb_issue_r0_ready", iss_ready, 1);
    step();
    iss_valid = 1'b0;
    for (int r = 0; r < 32; r++) begin
      chk_addr1 = 5'(r);
      #0.1;
      chk("sb_all_clear", chk_busy1, 0);
    end
    idle();
    step();

    // Register 0 MDU result drains silently.
    mdu_valid = 1'b1;
    mdu_waddr = 5'd0;
    mdu_wdata = 32'hBEEF;
    step();
    mdu_valid = 1'b0;
    #2;
    chk("r0_drain_no_write", rf_write, 0);
    chk("r0_drain_ready", mdu_ready, 1);
    step();
    #1;
    chk("r0_after_ready", mdu_ready, 1);
    chk("r0_after_no_write", rf_write, 0);
    step();

`ifdef REGFILE_WB_FWD_EN
    // Forwarding from a deferred buffer entry.
    iss_valid = 1'b1;
    iss_dest  = 5'd3;
    step();
    iss_valid  = 1'b0;
    pipe_we    = 1'b1;
    pipe_waddr = 5'd20;
    pipe_wdata = 32'h2020;
    mdu_valid  = 1'b1;
    mdu_waddr  = 5'd3;
    mdu_wdata  = 32'h55;
    #2;
    push(5'd20, 32'h2020);
    step();
    mdu_valid  = 1'b0;
    pipe_waddr = 5'd21;
    pipe_wdata = 32'h2121;
    chk_addr2  = 5'd3;
    #2;
    chk("fwd_hit2", fwd_hit2, 1);
    chk("fwd_data2", fwd_data2, 32'h55);
    chk("fwd_chk_busy2", chk_busy2, 0);
    chk("fwd_hit1_r0", fwd_hit1, 0);
    push(5'd21, 32'h2121);
    step();
    pipe_we = 1'b0;
    #2;
    push(5'd3, 32'h55);
    step();
    idle();
    step();
`endif

    // Reset mid-cycle with a full buffer and busy[5] set.
    iss_valid = 1'b1;
    iss_dest  = 5'd5;
    step();
    iss_valid  = 1'b0;
    pipe_we    = 1'b1;
    pipe_waddr = 5'd22;
    pipe_wdata = 32'h222;
    mdu_valid  = 1'b1;
    mdu_waddr  = 5'd5;
    mdu_wdata  = 32'h5555;
    #2;
    push(5'd22, 32'h222);
    step();
    mdu_valid  = 1'b0;
    pipe_waddr = 5'd23;
    pipe_wdata = 32'h233;
    chk_addr1  = 5'd5;
    #1;
    chk("pre_rst_busy5", chk_busy1, 1);
    chk("pre_rst_mdu_ready", mdu_ready, 0);
    #1;
    rst     = 1'b0;
    pipe_we = 1'b0;
    #1;
    chk("rst_rf_write", rf_write, 0);
    chk("rst_mdu_ready", mdu_ready, 1);
    chk("rst_chk_busy", chk_busy1, 0);
    chk("rst_stall", pipe_stall, 0);
    step();
    rst = 1'b1;
    iss_dest = 5'd5;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("post_rst_no_write", rf_write, 0);
      chk("post_rst_iss_ready5", iss_ready, 1);
      step();
    end

    idle();
    repeat (3) step();
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
